// File: rtl/feature_frame_loader.sv
// Packs NUM_FEAT quantized feature beats into a frame and hands it over 1 cycle after the last beat.
// Stalls s_ready only on the final beat while the previous frame is unclaimed. FEATURE_ROUND_EN selects round-half-up.
module feature_frame_loader #(
    parameter int NUM_FEAT = 11,
    parameter int IN_W     = 8,
    parameter int Q_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    feat_valid,
    input  logic                    feat_ready,
    output logic [NUM_FEAT*Q_W-1:0] feat_vec,
    output logic                    frame_err,
    output logic [15:0]             frame_cnt
);

    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_FEAT*Q_W-1:0]  shadow_q, shadow_d;
    logic [NUM_FEAT*Q_W-1:0]  vec_q, vec_d;
    logic                     valid_q, valid_d;
    logic                     err_q, err_d;
    logic [15:0]              cnt_q, cnt_d;

    logic [Q_W-1:0] q;
    logic           at_last;
    logic           accept;
    logic           handshake;

`ifdef FEATURE_ROUND_EN
    localparam int SH = IN_W - Q_W;
    localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (SH - 1);
    logic [IN_W:0] sum;
    logic [Q_W:0]  shifted;
    logic          unused_round;

    // One extra bit keeps the carry so saturation can be detected instead of wrapping.
    assign sum          = {1'b0, s_data} + HALF;
    assign shifted      = sum[IN_W:SH];
    assign q            = shifted[Q_W] ? {Q_W{1'b1}} : shifted[Q_W-1:0];
    assign unused_round = ^sum[SH-1:0];
`else
    logic unused_lsbs;

    assign q           = s_data[IN_W-1 -: Q_W];
    assign unused_lsbs = ^s_data[IN_W-Q_W-1:0];
`endif

    assign at_last   = (idx_q == LAST_IDX);
    assign s_ready   = !(at_last && valid_q && !feat_ready);
    assign accept    = s_valid && s_ready;
    assign handshake = valid_q && feat_ready;

    always_comb begin
        idx_d    = idx_q;
        shadow_d = shadow_q;
        vec_d    = vec_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q + 16'(handshake);

        if (handshake) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            shadow_d[int'(idx_q)*Q_W +: Q_W] = q;
            if (s_last != at_last) begin
                err_d = 1'b1;
                idx_d = '0;
            end else if (at_last) begin
                // Completion wins over a same-edge handshake so the output never bubbles.
                vec_d   = shadow_d;
                valid_d = 1'b1;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            shadow_q <= '0;
            vec_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            vec_q    <= vec_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign feat_vec   = vec_q;
    assign feat_valid = valid_q;
    assign frame_err  = err_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_feature_frame_loader.sv
// Directed bench: an 11-feature instance for framing/handshake behaviour and a
// 1-feature instance for quantization values and counter wrap.
module tb_feature_frame_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_last, feat_valid, feat_ready, frame_err;
    logic [7:0]  s_data;
    logic [43:0] feat_vec;
    logic [15:0] frame_cnt;

    logic        s1_valid, s1_ready, s1_last, f1_valid, f1_ready, f1_err;
    logic [7:0]  s1_data;
    logic [3:0]  f1_vec;
    logic [15:0] f1_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int hs;

    always #5 clk = ~clk;

    feature_frame_loader #(.NUM_FEAT(11), .IN_W(8), .Q_W(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_vec(feat_vec), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    feature_frame_loader #(.NUM_FEAT(1), .IN_W(8), .Q_W(4)) dut1 (
        .clk(clk), .rst(rst), .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data),
        .s_last(s1_last), .feat_valid(f1_valid), .feat_ready(f1_ready),
        .feat_vec(f1_vec), .frame_err(f1_err), .frame_cnt(f1_cnt)
    );

    typedef struct {
        logic        vld;
        logic [7:0]  dat;
        logic        last;
        logic        frdy;
        logic        e_srdy;
        logic        e_fv;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic l, input logic r,
                                input logic es, input logic ef, input logic ee, input logic [15:0] ec);
        vec_t t;
        t.vld = v; t.dat = d; t.last = l; t.frdy = r;
        t.e_srdy = es; t.e_fv = ef; t.e_err = ee; t.e_cnt = ec;
        tbl.push_back(t);
    endfunction

    function automatic logic [43:0] vec_up();
        logic [43:0] v;
        for (int k = 0; k < 11; k++) v[k*4 +: 4] = 4'(k);
        return v;
    endfunction

    function automatic logic [43:0] vec_down();
        logic [43:0] v;
        for (int k = 0; k < 11; k++) v[k*4 +: 4] = 4'(10 - k);
        return v;
    endfunction

    function automatic logic [7:0] up_dat(input int k);
        return 8'(16 * k + 7);
    endfunction

    function automatic logic [7:0] down_dat(input int k);
        return 8'(16 * (10 - k) + 3);
    endfunction

    task automatic beat(input logic [7:0] d, input logic l);
        s_valid = 1'b1; s_data = d; s_last = l;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic beat1(input logic [7:0] d, input logic [3:0] exp, input string name);
        s1_valid = 1'b1; s1_data = d; s1_last = 1'b1;
        @(posedge clk); #1;
        s1_valid = 1'b0;
        chk(name, 64'(f1_vec), 64'(exp));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; feat_ready = 1'b0;
        s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; f1_ready = 1'b1;

        // Directed vectors: nominal frame, early s_last, held output, missing s_last.
        for (int k = 0; k < 11; k++) add(1, up_dat(k), k == 10, 1, 1, k == 10, 0, 0);
        add(0, 8'h00, 0, 1, 1, 0, 0, 1);
        for (int k = 0; k < 6; k++) add(1, up_dat(k), k == 5, 0, 1, 0, k == 5, 1);
        for (int k = 0; k < 11; k++) add(1, down_dat(k), k == 10, 0, 1, k == 10, 0, 1);
        add(0, 8'h00, 0, 0, 1, 1, 0, 1);
        add(0, 8'h00, 0, 1, 1, 0, 0, 2);
        for (int k = 0; k < 11; k++) add(1, 8'h55, 0, 1, 1, 0, k == 10, 2);
        add(0, 8'h00, 0, 1, 1, 0, 0, 2);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_fv", 64'(feat_valid), 64'(0));
        chk("rst_vec", 64'(feat_vec), 64'(0));
        chk("rst_err", 64'(frame_err), 64'(0));
        chk("rst_cnt", 64'(frame_cnt), 64'(0));
        chk("rst_srdy", 64'(s_ready), 64'(1));

        // Quantization on the single-feature instance.
`ifdef FEATURE_ROUND_EN
        beat1(8'h87, 4'd8,  "q_87");
        beat1(8'h88, 4'd9,  "q_88");
        beat1(8'hF8, 4'd15, "q_F8");
`else
        beat1(8'h87, 4'd8,  "q_87");
        beat1(8'h88, 4'd8,  "q_88");
        beat1(8'hF8, 4'd15, "q_F8");
`endif

        // Counter wrap: one-beat frames with feat_ready held give a handshake per cycle.
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        s1_valid = 1'b1; s1_last = 1'b1; s1_data = 8'h40; f1_ready = 1'b1;
        hs = 0;
        for (int i = 0; i < 70000 && hs < 65536; i++) begin
            @(negedge clk);
            if (f1_valid && f1_ready) hs++;
            @(posedge clk); #1;
            if (hs == 65535) chk("cnt_ffff", 64'(f1_cnt), 64'(16'hFFFF));
        end
        s1_valid = 1'b0; f1_ready = 1'b0;
        chk("wrap_hs_seen", 64'(hs), 64'(65536));
        chk("cnt_wrap", 64'(f1_cnt), 64'(0));

        for (int i = 0; i < tbl.size(); i++) begin
            s_valid = tbl[i].vld; s_data = tbl[i].dat; s_last = tbl[i].last;
            feat_ready = tbl[i].frdy;
            @(negedge clk);
            chk($sformatf("t%0d_srdy", i), 64'(s_ready), 64'(tbl[i].e_srdy));
            @(posedge clk); #1;
            chk($sformatf("t%0d_fv", i), 64'(feat_valid), 64'(tbl[i].e_fv));
            chk($sformatf("t%0d_err", i), 64'(frame_err), 64'(tbl[i].e_err));
            chk($sformatf("t%0d_cnt", i), 64'(frame_cnt), 64'(tbl[i].e_cnt));
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("tbl_vec_kept", 64'(feat_vec), 64'(vec_down()));

        // Backpressure: second frame stalls on its last beat until the first is taken.
        feat_ready = 1'b0;
        for (int k = 0; k < 11; k++) beat(up_dat(k), k == 10);
        chk("bp_fv1", 64'(feat_valid), 64'(1));
        chk("bp_vec1", 64'(feat_vec), 64'(vec_up()));
        for (int k = 0; k < 10; k++) beat(down_dat(k), 1'b0);
        s_valid = 1'b1; s_data = down_dat(10); s_last = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk("bp_stall_srdy", 64'(s_ready), 64'(0));
            chk("bp_stall_vec", 64'(feat_vec), 64'(vec_up()));
            chk("bp_stall_fv", 64'(feat_valid), 64'(1));
            @(posedge clk); #1;
        end
        feat_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_srdy", 64'(s_ready), 64'(1));
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        chk("bp_fv_held", 64'(feat_valid), 64'(1));
        chk("bp_vec2", 64'(feat_vec), 64'(vec_down()));
        chk("bp_cnt3", 64'(frame_cnt), 64'(3));
        @(posedge clk); #1;
        chk("bp_fv_clear", 64'(feat_valid), 64'(0));
        chk("bp_cnt4", 64'(frame_cnt), 64'(4));
        feat_ready = 1'b0;

        // Reset mid-frame, then reset while a frame is held.
        for (int k = 0; k < 6; k++) beat(up_dat(k), 1'b0);
        s_valid = 1'b1; s_data = up_dat(6); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        chk("rm_fv", 64'(feat_valid), 64'(0));
        chk("rm_vec", 64'(feat_vec), 64'(0));
        chk("rm_err", 64'(frame_err), 64'(0));
        chk("rm_cnt", 64'(frame_cnt), 64'(0));
        chk("rm_srdy", 64'(s_ready), 64'(1));
        for (int k = 0; k < 10; k++) beat(up_dat(k), 1'b0);
        chk("rm_no_early", 64'(feat_valid), 64'(0));
        chk("rm_no_err", 64'(frame_err), 64'(0));
        beat(up_dat(10), 1'b1);
        chk("rm_fv_after", 64'(feat_valid), 64'(1));
        chk("rm_vec_after", 64'(feat_vec), 64'(vec_up()));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rh_fv", 64'(feat_valid), 64'(0));
        chk("rh_vec", 64'(feat_vec), 64'(0));
        chk("rh_err", 64'(frame_err), 64'(0));
        chk("rh_cnt", 64'(frame_cnt), 64'(0));
        chk("rh_srdy", 64'(s_ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
